matmul_operand_loader: RTL and testbench

- Upstream feeder for the 16x16 (2x2 tiles of 8x8) matrix-multiplication top.
- Accepts a valid/ready stream of 128-bit operand rows from the host side and writes them into the four operand BRAMs (A tile 0_0, A tile 1_0, B tile 0_0, B tile 0_1) through the top's shared address/data/write-enable path.
- Once all operand rows are written, it raises and holds start_mat_mul until the matmul reports done, then signals completion.

---
 rtl/matmul_pkg.sv | 15 +
 rtl/operand_write_port.sv | 41 ++++
 rtl/matmul_operand_loader.sv | 77 +++++++
 tb/tb_matmul_operand_loader.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared sizes, FSM states and beat-counter field layout for the matmul operand path
package matmul_pkg;
  localparam int DWIDTH = 16;
  localparam int BB_MAT_MUL_SIZE = 8;
  localparam int FINAL_MAT_MUL_SIZE = 16;
  localparam int AWIDTH = 7;
  localparam int NUM_TILES = 2;
  localparam int RWIDTH = BB_MAT_MUL_SIZE * DWIDTH;
  localparam int CWIDTH = $clog2(2 * NUM_TILES * BB_MAT_MUL_SIZE);
  localparam int ROW_W = $clog2(BB_MAT_MUL_SIZE);
  localparam int TILE_BIT = ROW_W;
  localparam int MAT_BIT = ROW_W + 1;
  localparam logic [CWIDTH-1:0] LAST_BEAT = '1;
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, DONE} state_t;
endpackage

// File: rtl/operand_write_port.sv
// operand_write_port: registers one accepted operand row into the shared BRAM write path
module operand_write_port import matmul_pkg::*; (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 accept,
  input  logic [CWIDTH-1:0]    cnt,
  input  logic [AWIDTH-1:0]    base,
  input  logic [RWIDTH-1:0]    in_data,
  output logic [AWIDTH-1:0]    addr_pi,
  output logic [RWIDTH-1:0]    data_pi,
  output logic [NUM_TILES-1:0] we_a,
  output logic [NUM_TILES-1:0] we_b
);
  logic [AWIDTH-1:0] addr_d, addr_q;
  logic [RWIDTH-1:0] data_d, data_q;
  logic [NUM_TILES-1:0] we_a_d, we_a_q, we_b_d, we_b_q, tile_we;
  always_comb begin
    tile_we = NUM_TILES'(1) << cnt[TILE_BIT];
    addr_d = accept ? base + AWIDTH'(cnt[ROW_W-1:0]) : addr_q;
    data_d = accept ? in_data : data_q;
    we_a_d = (accept && !cnt[MAT_BIT]) ? tile_we : '0;
    we_b_d = (accept && cnt[MAT_BIT]) ? tile_we : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      data_q <= '0;
      we_a_q <= '0;
      we_b_q <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      we_a_q <= we_a_d;
      we_b_q <= we_b_d;
    end
  end
  assign addr_pi = addr_q;
  assign data_pi = data_q;
  assign we_a = we_a_q;
  assign we_b = we_b_q;
endmodule

// File: rtl/matmul_operand_loader.sv
// matmul_operand_loader: streams A/B operand rows into the tile BRAMs, then runs one matmul job
module matmul_operand_loader import matmul_pkg::*; (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 go,
  input  logic [AWIDTH-1:0]    base_addr,
  input  logic [RWIDTH-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 enable_writing_to_mem,
  output logic [AWIDTH-1:0]    addr_pi,
  output logic [RWIDTH-1:0]    data_pi,
  output logic [NUM_TILES-1:0] we_a,
  output logic [NUM_TILES-1:0] we_b,
  output logic                 start_mat_mul,
  input  logic                 done_mat_mul,
  output logic                 busy,
  output logic                 job_done
);
  state_t state_d, state_q;
  logic [CWIDTH-1:0] cnt_d, cnt_q;
  logic [AWIDTH-1:0] base_d, base_q;
  logic start_d, start_q, accept;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    base_d = base_q;
    accept = (state_q == LOAD) && in_valid;
    unique case (state_q)
      IDLE: if (go) begin
        state_d = LOAD;
        base_d = base_addr;
        cnt_d = '0;
      end
      LOAD: if (accept) begin
        cnt_d = cnt_q + CWIDTH'(1);
        state_d = (cnt_q == LAST_BEAT) ? FLUSH : LOAD;
      end
      FLUSH: state_d = RUN;
      RUN: state_d = done_mat_mul ? DONE : RUN;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // registered so the matmul sees a glitch-free level
    start_d = (state_d == RUN);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      base_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      base_q <= base_d;
      start_q <= start_d;
    end
  end
  assign in_ready = (state_q == LOAD);
  assign enable_writing_to_mem = (state_q == LOAD) || (state_q == FLUSH);
  assign busy = (state_q != IDLE);
  assign job_done = (state_q == DONE);
  assign start_mat_mul = start_q;
  operand_write_port u_wr (
    .clk(clk),
    .reset_n(reset_n),
    .accept(accept),
    .cnt(cnt_q),
    .base(base_q),
    .in_data(in_data),
    .addr_pi(addr_pi),
    .data_pi(data_pi),
    .we_a(we_a),
    .we_b(we_b)
  );
endmodule

// File: tb/tb_matmul_operand_loader.sv
// tb_matmul_operand_loader: scoreboard bench; stimulus queues expected BRAM writes, a monitor pops them
module tb_matmul_operand_loader;
  import matmul_pkg::*;
  logic clk = 0, reset_n = 0, go = 0, in_valid = 0, done_mat_mul = 0;
  logic [AWIDTH-1:0] base_addr = '0;
  logic [RWIDTH-1:0] in_data = '0;
  logic in_ready, enable_writing_to_mem, start_mat_mul, busy, job_done;
  logic [AWIDTH-1:0] addr_pi;
  logic [RWIDTH-1:0] data_pi;
  logic [NUM_TILES-1:0] we_a, we_b;
  int n_chk = 0, n_pass = 0, jd_cnt = 0, mbeat = 0;
  logic [AWIDTH-1:0] mbase = '0;
  logic [159:0] exp_q[$];

  matmul_operand_loader dut (
    .clk(clk), .reset_n(reset_n), .go(go), .base_addr(base_addr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .enable_writing_to_mem(enable_writing_to_mem), .addr_pi(addr_pi),
    .data_pi(data_pi), .we_a(we_a), .we_b(we_b), .start_mat_mul(start_mat_mul),
    .done_mat_mul(done_mat_mul), .busy(busy), .job_done(job_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (job_done) jd_cnt++;
    if (|{we_a, we_b}) begin
      if (exp_q.size() == 0) chk("unexpected_write", 160'({addr_pi, data_pi, we_a, we_b}), 160'(0));
      else chk("write", 160'({addr_pi, data_pi, we_a, we_b}), exp_q.pop_front());
    end
  end

  task automatic beat(input logic [RWIDTH-1:0] d, input bit gap);
    int t = 0;
    int row, tile, mat;
    logic [AWIDTH-1:0] a;
    logic [NUM_TILES-1:0] wa, wb;
    if (gap) begin
      @(negedge clk);
      in_valid = 0;
    end
    @(negedge clk);
    in_valid = 1;
    in_data = d;
    while (!in_ready && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 160'(in_ready), 160'(1));
    else begin
      row = mbeat % 8;
      tile = (mbeat / 8) % 2;
      mat = mbeat / 16;
      a = mbase + AWIDTH'(row);
      wa = (mat == 0) ? NUM_TILES'(1 << tile) : '0;
      wb = (mat == 1) ? NUM_TILES'(1 << tile) : '0;
      exp_q.push_back(160'({a, d, wa, wb}));
      mbeat++;
    end
  endtask

  task automatic start_job(input logic [AWIDTH-1:0] b);
    @(negedge clk);
    go = 1;
    base_addr = b;
    mbase = b;
    mbeat = 0;
    @(negedge clk);
    go = 0;
    base_addr = ~b;
    chk("load_entry", {busy, enable_writing_to_mem, in_ready, start_mat_mul}, 4'b1110);
  endtask

  task automatic finish_job(input int run_cycles, input bit noise);
    int j0 = jd_cnt;
    @(negedge clk);
    in_valid = 0;
    chk("flush", {in_ready, enable_writing_to_mem, start_mat_mul, busy}, 4'b0101);
    @(negedge clk);
    chk("run_entry", {enable_writing_to_mem, start_mat_mul, busy, job_done}, 4'b0110);
    if (noise) go = 1;
    for (int i = 1; i < run_cycles; i++) begin
      @(negedge clk);
      go = 0;
      chk("run_hold", 160'(start_mat_mul), 160'(1));
    end
    done_mat_mul = 1;
    @(negedge clk);
    done_mat_mul = 0;
    go = 0;
    chk("done", {start_mat_mul, busy, job_done}, 3'b011);
    @(negedge clk);
    chk("idle", {start_mat_mul, busy, job_done, enable_writing_to_mem}, 4'b0000);
    chk("job_done_count", 160'(jd_cnt), 160'(j0 + 1));
    chk("sb_empty", 160'(exp_q.size()), 160'(0));
  endtask

  task automatic abort_job();
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    reset_n = 0;
    #1;
    chk("reset_outputs", {in_ready, enable_writing_to_mem, addr_pi, data_pi, we_a, we_b,
                          start_mat_mul, busy, job_done}, 160'(0));
    chk("abort_sb_empty", 160'(exp_q.size()), 160'(0));
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", {in_ready, enable_writing_to_mem, addr_pi, data_pi, we_a, we_b,
                        start_mat_mul, busy, job_done}, 160'(0));
    reset_n = 1;
    start_job(7'h10);
    for (int b = 0; b < 5; b++) beat({8{16'(16'hA000 + b)}}, 0);
    abort_job();
    start_job(7'h00);
    for (int b = 0; b < 32; b++) beat(RWIDTH'(b), 0);
    finish_job(3, 0);
    start_job(7'd124);
    for (int b = 0; b < 8; b++) beat({8{16'(16'h1240 + b)}}, 0);
    abort_job();
    start_job(7'h20);
    for (int b = 0; b < 32; b++) beat({RWIDTH'(b)} << 64 | RWIDTH'(32'hC0DE0000 + b), 1);
    finish_job(1, 0);
    start_job(7'h05);
    for (int b = 0; b < 32; b++) begin
      beat({4{32'(32'h5A000000 + b)}}, 0);
      if (b == 10) begin
        go = 1;
        done_mat_mul = 1;
      end
      if (b == 11) begin
        go = 0;
        done_mat_mul = 0;
      end
    end
    finish_job(100, 1);
    repeat (3) @(negedge clk);
    chk("total_jobs", 160'(jd_cnt), 160'(3));
    chk("final_idle", {busy, start_mat_mul, in_ready}, 3'b000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
